mat_mult_initiator: RTL and testbench

- Bus master for the MatrixMultiplication unit: accepts two 4x4 16-bit matrices from a client and issues the three transactions (load A, load B/compute, read result) on the unit's bus.
- Captures the product and returns it to the client with a one-cycle done pulse.
- Sits between the top-level sequencer/host logic and the multiplier.
- Always reloads A, because the responder clears its accumulator only on an A load.

---
 rtl/mat_bus_pkg.sv | 29 ++
 rtl/mat_gap_timer.sv | 34 +++
 rtl/mat_mult_initiator.sv | 204 ++++++++++++++++++++
 tb/tb_mat_mult_initiator.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mat_bus_pkg.sv
// Shared bus encodings, FSM state type and element packing helper for the
// MatrixMultiplication bus master.
package mat_bus_pkg;

    localparam int ELEM_W  = 16;
    localparam int MAT_DIM = 4;
    localparam int MAT_W   = 256;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;
    localparam logic SEL_A    = 1'b0;
    localparam logic SEL_B    = 1'b1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_A     = 3'd1,
        WR_B     = 3'd2,
        RD       = 3'd3,
        CAP      = 3'd4,
        DONE     = 3'd5,
        GAP_WAIT = 3'd6
    } matState_t;

    // Bit offset of element [i][j] in a row-major packed matrix.
    function automatic int unsigned elemOffset(input int unsigned i, input int unsigned j);
        return (i * MAT_DIM * ELEM_W) + (j * ELEM_W);
    endfunction

endpackage

// File: rtl/mat_gap_timer.sv
// Loadable down-counter with zero flag; times the idle gap after each
// bus command of the initiator.
module mat_gap_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] loadValue,
    input  logic             dec,
    output logic             zero
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count_r;

    // Gap counter: load wins over decrement, saturates at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= CNT_ZERO;
        end else if (load) begin
            count_r <= loadValue;
        end else if (dec && (count_r != CNT_ZERO)) begin
            count_r <= count_r - CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == CNT_ZERO);

endmodule

// File: rtl/mat_mult_initiator.sv
// Bus master for the MatrixMultiplication unit: load A, load B/compute, read.
// Optional macro MAT_CHAIN_EN adds pow_n and repeats the sequence for A*B^n.
module mat_mult_initiator #(
    parameter int GAP    = 0,
    parameter int ELEM_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [16*ELEM_W-1:0]  mat_a,
    input  logic [16*ELEM_W-1:0]  mat_b,
`ifdef MAT_CHAIN_EN
    input  logic [3:0]            pow_n,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [16*ELEM_W-1:0]  result,
    output logic [16*ELEM_W-1:0]  dataInBus,
    output logic                  RW,
    output logic                  enable,
    output logic                  matDecide,
    input  logic [16*ELEM_W-1:0]  fromMultBus
);
    import mat_bus_pkg::*;

    localparam int         BUS_W    = 16 * ELEM_W;
    localparam logic       GAP_EN   = (GAP != 0);
    localparam logic [3:0] GAP_LOAD = (GAP != 0) ? 4'(GAP - 1) : 4'd0;

    matState_t        state_r, nextState_s, retState_r;
    logic [BUS_W-1:0] matA_r, matB_r, result_r, dataInBus_r;
    logic [BUS_W-1:0] aOperand_s, busNext_s;
    logic             busy_r, done_r, RW_r, enable_r, matDecide_r;
    logic             timerLoad_s, timerDec_s, timerZero_s;
    logic             chainMore_s;

    mat_gap_timer #(.CNT_W(4)) gapTimer (
        .clk       (clk),
        .rst       (rst),
        .load      (timerLoad_s),
        .loadValue (GAP_LOAD),
        .dec       (timerDec_s),
        .zero      (timerZero_s)
    );

`ifdef MAT_CHAIN_EN
    logic [3:0] iterN_r, iterDone_r;

    assign chainMore_s = ({1'b0, iterDone_r} + 5'd1) < {1'b0, iterN_r};

    // Iteration bookkeeping: n latched at start, completed passes counted at CAP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iterN_r    <= 4'd0;
            iterDone_r <= 4'd0;
        end else if ((state_r == IDLE) && start) begin
            iterN_r    <= (pow_n == 4'd0) ? 4'd1 : pow_n;
            iterDone_r <= 4'd0;
        end else if ((state_r == CAP) && chainMore_s) begin
            iterDone_r <= iterDone_r + 4'd1;
        end else begin
            iterDone_r <= iterDone_r;
        end
    end
`else
    assign chainMore_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Next-state logic. No gap follows RD: the read data is only valid
    // on the cycle right after the read command, so CAP must follow at once.
    always_comb begin
        nextState_s = state_r;
        timerLoad_s = 1'b0;
        timerDec_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) nextState_s = WR_A;
                else       nextState_s = IDLE;
            end
            WR_A: begin
                if (GAP_EN) begin
                    nextState_s = GAP_WAIT;
                    timerLoad_s = 1'b1;
                end else begin
                    nextState_s = WR_B;
                end
            end
            WR_B: begin
                if (GAP_EN) begin
                    nextState_s = GAP_WAIT;
                    timerLoad_s = 1'b1;
                end else begin
                    nextState_s = RD;
                end
            end
            RD:   nextState_s = CAP;
            CAP: begin
                if (chainMore_s) nextState_s = WR_A;
                else             nextState_s = DONE;
            end
            DONE: nextState_s = IDLE;
            GAP_WAIT: begin
                if (timerZero_s) nextState_s = retState_r;
                else             timerDec_s  = 1'b1;
            end
            default: nextState_s = IDLE;
        endcase
    end

    // Command that a gap returns to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retState_r <= IDLE;
        end else if (state_r == WR_A) begin
            retState_r <= WR_B;
        end else if (state_r == WR_B) begin
            retState_r <= RD;
        end else begin
            retState_r <= retState_r;
        end
    end

    // A operand for the next WR_A: fresh input at start, product when chaining.
    always_comb begin
        aOperand_s = matA_r;
        if (state_r == IDLE) begin
            aOperand_s = mat_a;
        end else if (state_r == CAP) begin
            aOperand_s = fromMultBus;
        end else begin
            aOperand_s = matA_r;
        end
    end

    // Bus data for the coming cycle; holds outside write commands.
    always_comb begin
        busNext_s = dataInBus_r;
        if (nextState_s == WR_A) begin
            busNext_s = aOperand_s;
        end else if (nextState_s == WR_B) begin
            busNext_s = matB_r;
        end else begin
            busNext_s = dataInBus_r;
        end
    end

    // Operand latches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            matA_r <= {BUS_W{1'b0}};
            matB_r <= {BUS_W{1'b0}};
        end else if ((state_r == IDLE) && start) begin
            matA_r <= mat_a;
            matB_r <= mat_b;
        end else if ((state_r == CAP) && chainMore_s) begin
            matA_r <= fromMultBus;
        end else begin
            matA_r <= matA_r;
        end
    end

    // Registered bus and handshake outputs, decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable_r    <= 1'b0;
            RW_r        <= RW_READ;
            matDecide_r <= SEL_A;
            dataInBus_r <= {BUS_W{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            result_r    <= {BUS_W{1'b0}};
        end else begin
            enable_r    <= (nextState_s == WR_A) || (nextState_s == WR_B) || (nextState_s == RD);
            RW_r        <= ((nextState_s == WR_A) || (nextState_s == WR_B)) ? RW_WRITE : RW_READ;
            matDecide_r <= (nextState_s == WR_B) ? SEL_B : SEL_A;
            dataInBus_r <= busNext_s;
            busy_r      <= (nextState_s != IDLE) && (nextState_s != DONE);
            done_r      <= (nextState_s == DONE);
            if ((state_r == CAP) && !chainMore_s) begin
                result_r <= fromMultBus;
            end else begin
                result_r <= result_r;
            end
        end
    end

    assign enable    = enable_r;
    assign RW        = RW_r;
    assign matDecide = matDecide_r;
    assign dataInBus = dataInBus_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign result    = result_r;

endmodule

// File: tb/tb_mat_mult_initiator.sv
// Directed bench: two initiators (GAP=0 and GAP=3) each paired with a small
// behavioural MatrixMultiplication responder; expected values hand-computed.
`timescale 1ns/1ps
module tb_mat_mult_initiator;
    import mat_bus_pkg::*;

    localparam int BW  = 256;
    localparam int WIN = 40;

    localparam logic [63:0] EXP_EN   [2] = '{64'h0000_000E, 64'h0000_0222};
    localparam logic [63:0] EXP_MD   [2] = '{64'h0000_0004, 64'h0000_0020};
    localparam logic [63:0] EXP_RW   [2] = '{64'h0000_0006, 64'h0000_0022};
    localparam logic [63:0] EXP_BUSY [2] = '{64'h0000_001E, 64'h0000_07FE};
    localparam logic [63:0] EXP_DONE [2] = '{64'h0000_0020, 64'h0000_0800};

    logic clk = 1'b0;
    logic rst, start;
    logic [BW-1:0] matA, matB;
`ifdef MAT_CHAIN_EN
    logic [3:0] powN;
`endif

    logic busy0, done0, rw0, en0, md0, busy3, done3, rw3, en3, md3;
    logic [BW-1:0] result0, bus0, fromMult0, result3, bus3, fromMult3;
    logic [BW-1:0] respA0, acc0, respA3, acc3;

    logic [63:0]   enH [2], mdH [2], rwH [2], busyH [2], doneH [2];
    logic [BW-1:0] resH [2];
    int            aLoads [2];
    int            nCompared = 0;
    int            nMismatch = 0;

    always #5 clk = ~clk;

    mat_mult_initiator #(.GAP(0), .ELEM_W(16)) dut0 (
        .clk(clk), .rst(rst), .start(start), .mat_a(matA), .mat_b(matB),
`ifdef MAT_CHAIN_EN
        .pow_n(powN),
`endif
        .busy(busy0), .done(done0), .result(result0), .dataInBus(bus0),
        .RW(rw0), .enable(en0), .matDecide(md0), .fromMultBus(fromMult0)
    );

    mat_mult_initiator #(.GAP(3), .ELEM_W(16)) dut3 (
        .clk(clk), .rst(rst), .start(start), .mat_a(matA), .mat_b(matB),
`ifdef MAT_CHAIN_EN
        .pow_n(powN),
`endif
        .busy(busy3), .done(done3), .result(result3), .dataInBus(bus3),
        .RW(rw3), .enable(en3), .matDecide(md3), .fromMultBus(fromMult3)
    );

    function automatic logic [BW-1:0] diagMat(input logic [15:0] v);
        logic [BW-1:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) m[elemOffset(i, i) +: 16] = v;
        return m;
    endfunction

    function automatic logic [BW-1:0] fillMat(input logic [15:0] v);
        logic [BW-1:0] m;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) m[elemOffset(i, j) +: 16] = v;
        return m;
    endfunction

    function automatic logic [BW-1:0] seqMat();
        logic [BW-1:0] m;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) m[elemOffset(i, j) +: 16] = 16'(i * 4 + j + 1);
        return m;
    endfunction

    function automatic logic [BW-1:0] matMulAcc(input logic [BW-1:0] acc,
                                                input logic [BW-1:0] a,
                                                input logic [BW-1:0] b);
        logic [BW-1:0] m;
        logic [15:0]   s;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                s = acc[elemOffset(i, j) +: 16];
                for (int k = 0; k < 4; k++)
                    s = s + 16'(a[elemOffset(i, k) +: 16] * b[elemOffset(k, j) +: 16]);
                m[elemOffset(i, j) +: 16] = s;
            end
        return m;
    endfunction

    // Responder models: A load clears the accumulator, B load accumulates A*B,
    // read data appears on the cycle after the read command.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            respA0 <= '0; acc0 <= '0; fromMult0 <= '0;
        end else begin
            fromMult0 <= (en0 && !rw0) ? acc0 : '0;
            if (en0 && rw0 && !md0) begin respA0 <= bus0; acc0 <= '0; end
            else if (en0 && rw0 && md0) acc0 <= matMulAcc(acc0, respA0, bus0);
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            respA3 <= '0; acc3 <= '0; fromMult3 <= '0;
        end else begin
            fromMult3 <= (en3 && !rw3) ? acc3 : '0;
            if (en3 && rw3 && !md3) begin respA3 <= bus3; acc3 <= '0; end
            else if (en3 && rw3 && md3) acc3 <= matMulAcc(acc3, respA3, bus3);
        end
    end

    task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatch++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic checkZero(input string tag);
        chk({tag, "_ctl0"}, 256'({busy0, done0, rw0, en0, md0}), 256'd0);
        chk({tag, "_res0"}, result0, 256'd0);
        chk({tag, "_bus0"}, bus0, 256'd0);
        chk({tag, "_ctl3"}, 256'({busy3, done3, rw3, en3, md3}), 256'd0);
        chk({tag, "_res3"}, result3, 256'd0);
        chk({tag, "_bus3"}, bus3, 256'd0);
    endtask

    // Start in cycle 0, record cycles 1..WIN-1; optional re-assertion of start in cycles 2-3.
    task automatic runOp(input logic [BW-1:0] a, input logic [BW-1:0] b, input bit restart);
        for (int d = 0; d < 2; d++) begin
            enH[d] = '0; mdH[d] = '0; rwH[d] = '0; busyH[d] = '0; doneH[d] = '0; aLoads[d] = 0;
        end
        @(negedge clk);
        matA = a; matB = b; start = 1'b1;
        for (int c = 1; c < WIN; c++) begin
            @(negedge clk);
            enH[0][c] = en0; mdH[0][c] = md0; rwH[0][c] = rw0; busyH[0][c] = busy0; doneH[0][c] = done0;
            enH[1][c] = en3; mdH[1][c] = md3; rwH[1][c] = rw3; busyH[1][c] = busy3; doneH[1][c] = done3;
            if (en0 && rw0 && !md0) aLoads[0]++;
            if (en3 && rw3 && !md3) aLoads[1]++;
            if (restart && (c == 2 || c == 3)) begin
                start = 1'b1;
                matA  = fillMat(16'h0BAD);
            end else begin
                start = 1'b0;
            end
        end
        resH[0] = result0;
        resH[1] = result3;
    endtask

    task automatic checkRun(input string tag, input logic [BW-1:0] expRes);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_res_g%0d", tag, d * 3), resH[d], expRes);
            chk($sformatf("%s_en_g%0d", tag, d * 3), 256'(enH[d]), 256'(EXP_EN[d]));
            chk($sformatf("%s_md_g%0d", tag, d * 3), 256'(mdH[d]), 256'(EXP_MD[d]));
            chk($sformatf("%s_rw_g%0d", tag, d * 3), 256'(rwH[d]), 256'(EXP_RW[d]));
            chk($sformatf("%s_busy_g%0d", tag, d * 3), 256'(busyH[d]), 256'(EXP_BUSY[d]));
            chk($sformatf("%s_done_g%0d", tag, d * 3), 256'(doneH[d]), 256'(EXP_DONE[d]));
            chk($sformatf("%s_aload_g%0d", tag, d * 3), 256'(aLoads[d]), 256'd1);
        end
    endtask

    initial begin
        int doneSeen;
        rst = 1'b1; start = 1'b0; matA = '0; matB = '0;
`ifdef MAT_CHAIN_EN
        powN = 4'd0;
`endif
        repeat (2) @(negedge clk);
        checkZero("reset");
        rst = 1'b0;

        // Identity times sequence; full timing for both gap settings.
        runOp(diagMat(16'd1), seqMat(), 1'b0);
        checkRun("ident", seqMat());
        chk("busHold_g0", bus0, seqMat());
        chk("busHold_g3", bus3, seqMat());

        runOp(fillMat(16'h0001), fillMat(16'h0002), 1'b0);
        checkRun("fill", fillMat(16'h0008));

        runOp(diagMat(16'h0100), diagMat(16'h0100), 1'b0);
        checkRun("wrap", 256'd0);

        // start re-asserted mid-operation with other operands is ignored.
        runOp(diagMat(16'd1), seqMat(), 1'b1);
        checkRun("restart", seqMat());

        // Reset while dut0 is in WR_B.
        @(negedge clk);
        matA = seqMat(); matB = seqMat(); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("wrB_en_g0", 256'(en0), 256'd1);
        chk("wrB_md_g0", 256'(md0), 256'd1);
        rst = 1'b1;
        #1;
        checkZero("midRst");
        @(negedge clk);
        checkZero("midRstHold");
        rst = 1'b0;
        doneSeen = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (done0 || done3) doneSeen++;
        end
        chk("abortNoDone", 256'(doneSeen), 256'd0);
        runOp(diagMat(16'd1), diagMat(16'd2), 1'b0);
        checkRun("afterRst", diagMat(16'd2));

`ifdef MAT_CHAIN_EN
        powN = 4'd3;
        runOp(diagMat(16'd2), diagMat(16'd2), 1'b0);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("chain3_res_g%0d", d * 3), resH[d], diagMat(16'h0010));
            chk($sformatf("chain3_aload_g%0d", d * 3), 256'(aLoads[d]), 256'd3);
            chk($sformatf("chain3_done_g%0d", d * 3), 256'($countones(doneH[d])), 256'd1);
        end
        chk("chain3_doneAt_g0", 256'(doneH[0]), 256'(64'h0000_2000));
        powN = 4'd0;
        runOp(diagMat(16'd2), diagMat(16'd2), 1'b0);
        checkRun("chain0", diagMat(16'd4));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
